// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered result, status flags and error.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (MULA).
package alu_mc_pkg;
    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_LDCA = 6'h01;
    localparam logic [5:0] OP_LDCB = 6'h02;
    localparam logic [5:0] OP_LDA  = 6'h03;
    localparam logic [5:0] OP_LDB  = 6'h04;
    localparam logic [5:0] OP_STA  = 6'h05;
    localparam logic [5:0] OP_STB  = 6'h06;
    localparam logic [5:0] OP_ADDA = 6'h07;
    localparam logic [5:0] OP_ADDB = 6'h08;
    localparam logic [5:0] OP_SUBA = 6'h09;
    localparam logic [5:0] OP_ANDA = 6'h0A;
    localparam logic [5:0] OP_ORA  = 6'h0B;
    localparam logic [5:0] OP_XORA = 6'h0C;
    localparam logic [5:0] OP_NOTA = 6'h0D;
    localparam logic [5:0] OP_SHLA = 6'h0E;
    localparam logic [5:0] OP_SHRA = 6'h0F;
    localparam logic [5:0] OP_MULA = 6'h10;
endpackage

module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] rWrData,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic              err
);

    localparam int MSB = DATA_W - 1;

    logic              accept;
    logic              is_mul;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   dif;
    logic [DATA_W:0]   shl;
    logic [DATA_W:0]   shr;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_err;
    logic              wb_en;
    logic [DATA_W-1:0] wb_res;
    logic              wb_c;
    logic              wb_v;
    logic              wb_err;

    assign accept = in_valid & in_ready;

    // Extra bit on each side catches the last bit shifted out; amounts
    // above DATA_W shift zeros through it, giving carry 0.
    assign sum = {1'b0, in1} + {1'b0, in2};
    assign dif = {1'b0, in1} - {1'b0, in2};
    assign shl = {1'b0, in1} << in2;
    assign shr = {in1, 1'b0} >> in2;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (opcode)
            OPC_W'(OP_NOP), OPC_W'(OP_LDCA), OPC_W'(OP_LDCB),
            OPC_W'(OP_LDA), OPC_W'(OP_LDB): alu_res = '0;
            OPC_W'(OP_STA): alu_res = in1;
            OPC_W'(OP_STB): alu_res = in2;
            OPC_W'(OP_ADDA), OPC_W'(OP_ADDB): begin
                {alu_c, alu_res} = sum;
                alu_v = (in1[MSB] == in2[MSB]) & (sum[MSB] != in1[MSB]);
            end
            OPC_W'(OP_SUBA): begin
                {alu_c, alu_res} = dif;
                alu_v = (in1[MSB] != in2[MSB]) & (dif[MSB] != in1[MSB]);
            end
            OPC_W'(OP_ANDA): alu_res = in1 & in2;
            OPC_W'(OP_ORA):  alu_res = in1 | in2;
            OPC_W'(OP_XORA): alu_res = in1 ^ in2;
            OPC_W'(OP_NOTA): alu_res = ~in1;
            OPC_W'(OP_SHLA): {alu_c, alu_res} = shl;
            OPC_W'(OP_SHRA): {alu_res, alu_c} = shr;
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

    state_t              state, state_nx;
    logic [2*DATA_W-1:0] acc, acc_nx;
    logic [2*DATA_W-1:0] mcand, mcand_nx;
    logic [DATA_W-1:0]   mplier, mplier_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic                mul_done;

    assign in_ready = (state == S_IDLE);
    assign is_mul   = (opcode == OPC_W'(OP_MULA));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            acc    <= acc_nx;
            mcand  <= mcand_nx;
            mplier <= mplier_nx;
            cnt    <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        acc_nx    = acc;
        mcand_nx  = mcand;
        mplier_nx = mplier;
        cnt_nx    = cnt;
        mul_done  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_nx  = S_MUL;
                    acc_nx    = '0;
                    mcand_nx  = {{DATA_W{1'b0}}, in1};
                    mplier_nx = in2;
                    cnt_nx    = '0;
                end
            end
            S_MUL: begin
                // One partial product per cycle; the last one is folded
                // straight into the writeback on the final edge.
                acc_nx    = acc + (mplier[0] ? mcand : '0);
                mcand_nx  = mcand << 1;
                mplier_nx = mplier >> 1;
                cnt_nx    = cnt + 1'b1;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    mul_done = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wb_en  = 1'b0;
        wb_res = alu_res;
        wb_c   = alu_c;
        wb_v   = alu_v;
        wb_err = alu_err;
        if (mul_done) begin
            wb_en  = 1'b1;
            wb_res = acc_nx[DATA_W-1:0];
            wb_c   = |acc_nx[2*DATA_W-1:DATA_W];
            wb_v   = 1'b0;
            wb_err = 1'b0;
        end else if (accept && !is_mul) begin
            wb_en = 1'b1;
        end
    end
`else
    assign in_ready = 1'b1;
    assign is_mul   = 1'b0;

    always_comb begin
        wb_en  = accept & ~is_mul;
        wb_res = alu_res;
        wb_c   = alu_c;
        wb_v   = alu_v;
        wb_err = alu_err;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            rWrData   <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= wb_en;
            if (wb_en) begin
                rWrData <= wb_res;
                flag_c  <= wb_c;
                flag_z  <= (wb_res == '0);
                flag_n  <= wb_res[MSB];
                flag_v  <= wb_v;
                err     <= wb_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc, 8-bit datapath.
// Honours ALU_MUL_EN the same way the design does.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [5:0]   opcode = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] rWrData;
    logic         flag_c, flag_z, flag_n, flag_v, err;

    typedef struct {
        logic [12:0] val;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   st;

    alu_mc #(.DATA_W(W), .OPC_W(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .in1(in1), .in2(in2), .in_valid(in_valid),
        .in_ready(in_ready), .out_valid(out_valid),
        .rWrData(rWrData), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {result, c, z, n, v, err}
    function automatic logic [12:0] model(input logic [5:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        int x, sa, sb;
        logic [W-1:0] r, t;
        logic c, v, e;
        r = '0; c = 1'b0; v = 1'b0; e = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        if (op inside {OP_NOP, OP_LDCA, OP_LDCB, OP_LDA, OP_LDB}) begin
            r = '0;
        end else if (op == OP_STA) r = a;
        else if (op == OP_STB) r = b;
        else if (op == OP_ADDA || op == OP_ADDB) begin
            x = int'(a) + int'(b);
            r = x[W-1:0];
            c = (x > 255);
            v = (sa + sb > 127) || (sa + sb < -128);
        end else if (op == OP_SUBA) begin
            x = int'(a) - int'(b);
            r = x[W-1:0];
            c = (x < 0);
            v = (sa - sb > 127) || (sa - sb < -128);
        end else if (op == OP_ANDA) r = a & b;
        else if (op == OP_ORA) r = a | b;
        else if (op == OP_XORA) r = a ^ b;
        else if (op == OP_NOTA) r = ~a;
        else if (op == OP_SHLA || op == OP_SHRA) begin
            t = a;
            for (int i = 0; i < int'(b); i++) begin
                if (op == OP_SHLA) begin
                    c = t[W-1];
                    t = t << 1;
                end else begin
                    c = t[0];
                    t = t >> 1;
                end
            end
            r = t;
        end else if (op == OP_MULA && MUL_EN) begin
            x = int'(a) * int'(b);
            r = x[W-1:0];
            c = (x > 255);
        end else begin
            e = 1'b1;
        end
        return {r, c, (r == '0), r[W-1], v, e};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk(e.tag, {19'd0, rWrData, flag_c, flag_z, flag_n,
                            flag_v, err}, {19'd0, e.val});
                chk({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [5:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string tag,
                        output int stalls);
        exp_t e;
        bit   rdy;
        bit   tmo;
        int   c0;
        stalls = 0;
        tmo = 1'b0;
        opcode = op;
        in1 = a;
        in2 = b;
        in_valid = 1'b1;
        forever begin
            rdy = in_ready;
            c0 = cyc;
            @(posedge clk);
            if (rdy) break;
            stalls++;
            if (stalls > 50) begin
                chk({tag, "_timeout"}, 1, 0);
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!tmo) begin
            e.val = model(op, a, b);
            e.tag = tag;
            e.cyc = c0 + 1 + ((MUL_EN && op == OP_MULA) ? W : 0);
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {out_valid, rWrData, flag_c, flag_z, flag_n,
                            flag_v, err}, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1'b1;

        send(OP_ADDA, 8'hF0, 8'h20, "adda_f0_20", st);
        send(OP_STA, 8'h5A, 8'h00, "sta_5a", st);
        chk("b2b_stall", st, 0);
        send(OP_STB, 8'h11, 8'hC3, "stb_c3", st);
        send(OP_SUBA, 8'h80, 8'h01, "suba_80_01", st);
        send(OP_SUBA, 8'h01, 8'h02, "suba_01_02", st);
        send(OP_ADDB, 8'h7F, 8'h01, "addb_ovf", st);
        send(OP_ANDA, 8'hCC, 8'hAA, "anda", st);
        send(OP_ORA, 8'hCC, 8'hAA, "ora", st);
        send(OP_XORA, 8'hCC, 8'hCC, "xora_zero", st);
        send(OP_NOTA, 8'h0F, 8'h00, "nota", st);
        send(OP_SHLA, 8'h81, 8'd1, "shla_1", st);
        send(OP_SHRA, 8'h81, 8'd9, "shra_9", st);
        send(OP_SHLA, 8'h81, 8'd0, "shla_0", st);
        send(OP_SHLA, 8'h81, 8'd8, "shla_8", st);
        send(OP_SHRA, 8'h81, 8'd8, "shra_8", st);
        send(OP_SHRA, 8'h81, 8'd1, "shra_1", st);
        send(OP_SHLA, 8'h81, 8'd200, "shla_200", st);
        send(6'h3F, 8'h12, 8'h34, "illegal_3f", st);
        send(OP_LDA, 8'hFF, 8'hFF, "lda", st);

        send(OP_MULA, 8'd13, 8'd11, "mula_13x11", st);
        send(OP_ADDA, 8'd1, 8'd2, "adda_held", st);
        chk("mul_stall", st, MUL_EN ? W : 0);
        send(OP_MULA, 8'd16, 8'd16, "mula_16x16", st);
        send(OP_MULA, 8'd3, 8'd3, "mula_3x3", st);
        send(OP_MULA, 8'hFF, 8'hFF, "mula_ffxff", st);
        repeat (W + 2) @(negedge clk);
        chk("drain_pre_rst", q.size(), 0);

        send(OP_MULA, 8'd7, 8'd9, "mula_rst", st);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b1;
        opcode = OP_STA;
        in1 = 8'hEE;
        q.delete();
        @(negedge clk);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_outputs", {out_valid, rWrData, flag_c, flag_z,
                               flag_n, flag_v, err}, 0);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (W + 4) @(negedge clk);

        send(OP_SUBA, 8'h05, 8'h05, "suba_zero", st);
        send(OP_ADDA, 8'h80, 8'h80, "adda_neg_ovf", st);
        repeat (W + 4) @(negedge clk);
        chk("drain_end", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the next-generation datapath unit of the processor core. It accepts one operation per valid/ready handshake on a DATA_W-bit datapath. It extends the original transfer and add operations with subtract, logic, shift and an iterative shift-add multiply. Every result is registered together with status flags and an error indication, and is delivered to the register-file write port.

## Interface
- DATA_W, 8, datapath width (≥4).
- OPC_W, 6, opcode width; encodings are the shared opcode definitions, with new mnemonics added there.
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- opcode  in  OPC_W  operation select.
- in1  in  DATA_W  operand A.
- in2  in  DATA_W  operand B.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept (combinational, = state IDLE).
- out_valid  out  1  one-cycle pulse, result/flags valid.
- rWrData  out  DATA_W  result; holds last value between pulses.
- flag_c  out  1  carry / borrow / shifted-out bit / multiply high-half nonzero.
- flag_z  out  1  rWrData == 0.
- flag_n  out  1  rWrData[DATA_W-1].
- flag_v  out  1  signed overflow (ADDx/SUBx only).
- err  out  1  illegal opcode, qualified by out_valid.

## Operation
- Accept happens at a rising edge with in_valid & in_ready. Operands and opcode are captured at that edge.
- Single-cycle ops:
  - LDCA, LDCB, LDA, LDB, NOP: result 0.
  - STA: result is in1.
  - STB: result is in2.
  - ADDA, ADDB: in1+in2. flag_c = carry-out. flag_v = (a,b same sign) & result sign differs.
  - SUBA: in1−in2. flag_c = borrow (in1<in2 unsigned). flag_v = signed overflow.
  - ANDA, ORA, XORA: bitwise. NOTA: ~in1.
  - SHLA: in1 << in2, unsigned. SHRA: in1 >> in2, logical. flag_c = last bit shifted out. Shift amount 0 gives flag_c=0. Amount ≥ DATA_W gives result 0, with flag_c = in1 bit that would exit last at amount DATA_W (SHL: bit 0, SHR: bit DATA_W−1) only when the amount equals DATA_W exactly, otherwise 0.
- Flags not listed for an op are 0, except flag_z and flag_n, which always reflect the result.
- MULA (when compiled in): unsigned shift-add.
  - FSM: IDLE → MUL on accept.
  - MUL runs DATA_W iterations using a 2·DATA_W accumulator, an iteration counter of $clog2(DATA_W)+1 bits, and a multiplier shift register.
  - After the last iteration: MUL → IDLE.
  - rWrData = low DATA_W bits of the product. flag_c = |high half. flag_v = 0.
- Illegal or unlisted opcode: single-cycle; result 0, err=1, flag_z=1.
- Reset (reset=0 at an edge):
  - state IDLE; rWrData, all flags, err and out_valid = 0; accumulator and counter cleared.
  - Any in-flight MULA is discarded and produces no out_valid.
  - Inputs are ignored while reset=0.

## Timing
- Single-cycle op accepted at edge N: out_valid=1 with result during the cycle after edge N, deasserted at N+1 unless a new op is accepted at N+1. Back-to-back throughput is 1 op/cycle; in_ready stays 1.
- MULA accepted at edge N:
  - in_ready=0 from after N until out_valid.
  - out_valid asserted at edge N+DATA_W (latency DATA_W cycles).
  - in_ready returns to 1 in the same cycle as out_valid, so a new op can be accepted at edge N+DATA_W+1.
- in_valid during MUL is ignored (not accepted, no side effect). The requester must hold it.
- No combinational path from inputs to any output except in_ready, which depends on state only.

## Configuration
- ALU_MUL_EN defined: MULA is implemented as above with the MUL state, accumulator and counter.
- ALU_MUL_EN undefined: no multiplier hardware. MULA is treated as illegal (single cycle, result 0, err=1). in_ready is constant 1 after reset.

## Test plan
- ADDA in1=8'hF0, in2=8'h20 → rWrData=8'h10, c=1, z=0, n=0, v=0, out_valid one cycle after accept; back-to-back STA in1=8'h5A next cycle → 8'h5A on the following cycle.
- SUBA 8'h80−8'h01 → 8'h7F, c=0, v=1, n=0; SUBA 8'h01−8'h02 → 8'hFF, c=1, n=1, v=0.
- MULA (ALU_MUL_EN) 13×11 → 8'h8F, c=0, out_valid exactly 8 cycles after accept, in_ready low for 8 cycles; an ADDA held on in_valid during MUL is accepted only after. MULA 16×16 → 8'h00, z=1, c=1.
- Reset driven low during the 3rd MUL cycle → next cycle state IDLE, in_ready=1, out_valid never pulses for that MULA, rWrData=0.
- SHLA 8'h81 by 1 → 8'h02, c=1; SHRA 8'h81 by 9 → 8'h00, c=0, z=1; SHLA by 0 → unchanged, c=0.
- Opcode 6'h3F → rWrData=0, err=1, z=1; with ALU_MUL_EN undefined, MULA 3×3 → err=1, result 0, 1-cycle latency.
